// File: rtl/bot_permute_scheduler.sv
// Bot permute scheduler: queues bot jobs and launches one permuter burst per
// job when the permuter is nearly done and the downstream consumer has room.
module bot_permute_scheduler #(
  parameter int EXTRA_DATA_WIDTH = 12,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inValid,
  output logic                        inReady,
  input  logic [127:0]                botIn,
  input  logic [5:0]                  validBotPermutesIn,
  input  logic [EXTRA_DATA_WIDTH-1:0] extraDataIn,
  input  logic                        flush,
  input  logic                        permuterDone,
  input  logic                        downstreamAlmostFull,
  output logic                        startNewBurst,
  output logic [127:0]                botOut,
  output logic [5:0]                  validBotPermutesOut,
  output logic [EXTRA_DATA_WIDTH-1:0] extraDataOut,
  output logic [31:0]                 burstCount,
  output logic [31:0]                 permuteCount,
  output logic [15:0]                 droppedCount,
  output logic                        idle
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {STARTUP, RUN} state_t;

  state_t                      state;
  state_t                      state_next;
  logic [1:0]                  startup_cnt;
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic [CW-1:0]               count;
  logic [127:0]                bot_mem   [FIFO_DEPTH];
  logic [5:0]                  mask_mem  [FIFO_DEPTH];
  logic [EXTRA_DATA_WIDTH-1:0] extra_mem [FIFO_DEPTH];
  logic                        in_run;
  logic                        empty;
  logic                        full;
  logic                        push;
  logic                        pop;
  logic                        drop;
  logic [2:0]                  head_pop;

  // Head entry straight from storage registers.
  always_comb begin
    botOut              = bot_mem[rd_ptr];
    validBotPermutesOut = mask_mem[rd_ptr];
    extraDataOut        = extra_mem[rd_ptr];
  end

  // Handshake, launch and drop decisions from registered occupancy and state.
  always_comb begin
    in_run        = (state == RUN);
    empty         = (count == '0);
    full          = (count == CW'(FIFO_DEPTH));
    inReady       = in_run && !full && !flush;
    push          = inValid && inReady;
    startNewBurst = in_run && !empty && (validBotPermutesOut != '0) &&
                    permuterDone && !downstreamAlmostFull && !flush;
    drop          = in_run && !empty && (validBotPermutesOut == '0) && !flush;
    pop           = startNewBurst || drop;
    idle          = in_run && empty && permuterDone;
  end

  // Number of permutations in the head job.
  always_comb begin
    head_pop = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      head_pop = head_pop + 3'(validBotPermutesOut[i]);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= STARTUP;
    else     state <= state_next;
  end

  // Next state: leave STARTUP after three cycles, RUN is sticky.
  always_comb begin
    state_next = state;
    case (state)
      STARTUP: if (startup_cnt == 2'd2) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = STARTUP;
    endcase
  end

  // Startup holdoff counter, covers the permuter's local reset pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      startup_cnt <= '0;
    end else if (state == STARTUP && startup_cnt != 2'd2) begin
      startup_cnt <= startup_cnt + 2'd1;
    end
  end

  // FIFO pointers and occupancy; flush empties the queue without push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage, written on accepted push only.
  always_ff @(posedge clk) begin
    if (push) begin
      bot_mem[wr_ptr]   <= botIn;
      mask_mem[wr_ptr]  <= validBotPermutesIn;
      extra_mem[wr_ptr] <= extraDataIn;
    end
  end

  // Statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burstCount   <= '0;
      permuteCount <= '0;
      droppedCount <= '0;
    end else begin
      if (startNewBurst) begin
        burstCount   <= burstCount + 32'd1;
        permuteCount <= permuteCount + 32'(head_pop);
      end
      if (drop && droppedCount != '1) droppedCount <= droppedCount + 16'd1;
    end
  end

endmodule
